// File: rtl/dcache_axi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dcache_axi_if                                                   |
// | Brief    : AXI4 read/write channel bundle between dcache_axi and memory.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface dcache_axi_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arlen, arvalid,
    input  arready,
    input  rdata, rlast, rvalid,
    output rready,
    output awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arvalid,
    output arready,
    output rdata, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/dcache_axi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dcache_axi                                                      |
// | Brief    : Cache line refill/writeback to AXI4 4-beat INCR burst bridge.   |
// |            Option macro DCACHE_AXI_EARLY_W_EN: W beats overlap AW phase.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dcache_axi #(
  parameter int BURST_LEN = 4
) (
  input  wire                      clk,
  input  wire                      rst,
  output logic                     dev_rrdy,
  input  wire  [3:0]               cpu_ren,
  input  wire  [31:0]              cpu_raddr,
  output logic                     dev_rvalid,
  output logic [32*BURST_LEN-1:0]  dev_rdata,
  output logic                     dev_wrdy,
  input  wire  [3:0]               cpu_wen,
  input  wire  [31:0]              cpu_waddr,
  input  wire  [32*BURST_LEN-1:0]  cpu_wdata,
  dcache_axi_if.master             axi
);

  localparam int       c_CNT_W = $clog2(BURST_LEN);
  localparam bit [7:0] c_LEN   = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_t;

  rstate_t            r_rstate, w_rnext;
  wstate_t            r_wstate, w_wnext;
  logic [31:0]        r_araddr, r_awaddr;
  logic [c_CNT_W-1:0] r_rcnt, r_wcnt;
  logic [31:0]        r_rword [BURST_LEN];
  logic [31:0]        r_wword [BURST_LEN];

  logic w_widle, w_wlast, w_w_hs;
  logic w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
  logic w_unused;

  assign w_unused = ^{cpu_raddr[3:0], cpu_waddr[3:0]};

  assign w_widle = (r_wstate == W_IDLE);
  assign w_wlast = (r_wcnt == c_CNT_W'(BURST_LEN - 1));
  assign w_w_hs  = w_wvalid & axi.wready;

  assign axi.araddr  = r_araddr;
  assign axi.arlen   = c_LEN;
  assign axi.arvalid = w_arvalid;
  assign axi.rready  = w_rready;
  assign axi.awaddr  = r_awaddr;
  assign axi.awlen   = c_LEN;
  assign axi.awvalid = w_awvalid;
  assign axi.wdata   = r_wword[r_wcnt];
  assign axi.wstrb   = 4'hF;
  assign axi.wlast   = w_wlast;
  assign axi.wvalid  = w_wvalid;
  assign axi.bready  = w_bready;

  for (genvar i = 0; i < BURST_LEN; i++) begin : g_rpack
    assign dev_rdata[32*i +: 32] = r_rword[i];
  end

  // ---------------------------------------------------------------- read FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rstate <= R_IDLE;
    else      r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext    = r_rstate;
    dev_rrdy   = 1'b0;
    dev_rvalid = 1'b0;
    w_arvalid  = 1'b0;
    w_rready   = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        dev_rrdy = 1'b1;
        if (|cpu_ren) w_rnext = R_AR;
      end
      R_AR: begin
        // Hold the refill back until any writeback has fully retired
        w_arvalid = w_widle;
        if (w_widle && axi.arready) w_rnext = R_DATA;
      end
      R_DATA: begin
        w_rready = 1'b1;
        if (axi.rvalid && axi.rlast) w_rnext = R_DONE;
      end
      R_DONE: begin
        dev_rvalid = 1'b1;
        w_rnext    = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_araddr <= '0;
      r_rcnt   <= '0;
      for (int i = 0; i < BURST_LEN; i++) r_rword[i] <= '0;
    end else begin
      if (r_rstate == R_IDLE && |cpu_ren) begin
        r_araddr <= {cpu_raddr[31:4], 4'h0};
        r_rcnt   <= '0;
      end
      if (r_rstate == R_DATA && axi.rvalid) begin
        r_rword[r_rcnt] <= axi.rdata;
        r_rcnt          <= r_rcnt + c_CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------- write FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wstate <= W_IDLE;
    else      r_wstate <= w_wnext;
  end

`ifdef DCACHE_AXI_EARLY_W_EN
  logic r_aw_done, r_w_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_wstate != W_AW) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_awvalid && axi.awready) r_aw_done <= 1'b1;
      if (w_w_hs && w_wlast)        r_w_done  <= 1'b1;
    end
  end
`endif

  always_comb begin
    w_wnext   = r_wstate;
    dev_wrdy  = 1'b0;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        dev_wrdy = 1'b1;
        if (|cpu_wen) w_wnext = W_AW;
      end
      W_AW: begin
`ifdef DCACHE_AXI_EARLY_W_EN
        // AW and W complete independently; leave once both have retired
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        if ((r_aw_done || axi.awready) && (r_w_done || (axi.wready && w_wlast)))
          w_wnext = W_RESP;
`else
        w_awvalid = 1'b1;
        if (axi.awready) w_wnext = W_DATA;
`endif
      end
      W_DATA: begin
        w_wvalid = 1'b1;
        if (axi.wready && w_wlast) w_wnext = W_RESP;
      end
      W_RESP: begin
        w_bready = 1'b1;
        if (axi.bvalid) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_awaddr <= '0;
      r_wcnt   <= '0;
      for (int i = 0; i < BURST_LEN; i++) r_wword[i] <= '0;
    end else begin
      if (r_wstate == W_IDLE && |cpu_wen) begin
        r_awaddr <= {cpu_waddr[31:4], 4'h0};
        r_wcnt   <= '0;
        for (int i = 0; i < BURST_LEN; i++) r_wword[i] <= cpu_wdata[32*i +: 32];
      end else if (w_w_hs) begin
        r_wcnt <= r_wcnt + c_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
